// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the radix-2^2 SDF FFT pipeline.
package fft_pkg;

    // Default input component width of the pipeline.
    localparam int FFT_WIDTH = 16;

    // Feedback delay depth of each of the four butterfly stages of the 16-point FFT.
    localparam int STAGE0_DEPTH = 8;
    localparam int STAGE1_DEPTH = 4;
    localparam int STAGE2_DEPTH = 2;
    localparam int STAGE3_DEPTH = 1;

    // Complex sample at the default width after one bit of butterfly growth.
    // Stages built at another width declare the same layout locally
    // with their own WIDTH.
    typedef struct packed {
        logic signed [FFT_WIDTH:0] re;
        logic signed [FFT_WIDTH:0] im;
    } cpx_t;

    // Control counter width. It counts one full frame of 2*DEPTH samples,
    // and its MSB is the butterfly phase.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Delay-line pointer width. It is kept at one bit or more so that DEPTH=1 still has a legal vector.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Circular feedback buffer of DEPTH words with a single read/write pointer.
// The read is asynchronous, so the word leaving the buffer is available in
// the same cycle that its slot is overwritten.
module sdf_delay_line
    import fft_pkg::*;
#(
    parameter int DEPTH = STAGE0_DEPTH,
    parameter int DW    = 2 * (FFT_WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data
);

    localparam int            PW   = ptr_width(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] ptr;

    // The oldest entry is the one the pointer sits on. It leaves as the new word takes its slot.
    assign rd_data = mem[ptr];

    // Pointer and storage. A reset clears every entry so that no partial frame leaks forward.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            mem[ptr] <= wr_data;
            ptr      <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage.
// Phase 0 stores the incoming sample and emits the difference that was left by the previous frame.
// Phase 1 emits the sum of the sample with its partner DEPTH positions earlier,
// and stores their difference for the next frame.
module sdf_bf_stage
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH,
    parameter int DEPTH = STAGE0_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic                    out_valid,
    output logic signed [WIDTH:0]   out_re,
    output logic signed [WIDTH:0]   out_im,
    output logic                    out_bf
);

    localparam int CW = cnt_width(DEPTH);
    localparam int XW = WIDTH + 1;

    typedef struct packed {
        logic signed [XW-1:0] re;
        logic signed [XW-1:0] im;
    } cpx_w_t;

    // One guard bit is added to each component. Inputs are bounded by 2^(WIDTH-1),
    // so d+x and d-x always fit and need no saturation.
    function automatic cpx_w_t widen(input logic signed [WIDTH-1:0] re,
                                     input logic signed [WIDTH-1:0] im);
        cpx_w_t r;
        r.re = {re[WIDTH-1], re};
        r.im = {im[WIDTH-1], im};
        return r;
    endfunction

    function automatic cpx_w_t cadd(input cpx_w_t a, input cpx_w_t b);
        cpx_w_t r;
        r.re = a.re + b.re;
        r.im = a.im + b.im;
        return r;
    endfunction

    function automatic cpx_w_t csub(input cpx_w_t a, input cpx_w_t b);
        cpx_w_t r;
        r.re = a.re - b.re;
        r.im = a.im - b.im;
        return r;
    endfunction

    logic [CW-1:0] cnt;
    logic          phase;
    logic          primed;

    cpx_w_t x_p0;
    cpx_w_t d_p0;
    cpx_w_t sum_p0;
    cpx_w_t diff_p0;
    cpx_w_t wr_p0;

    logic   vld_p1;
    cpx_w_t res_p1;
    logic   bf_p1;

    assign phase = cnt[CW-1];

    // Input stage: widen the sample, form the butterfly against the fed-back word,
    // and choose what goes back into the delay line.
    always_comb begin
        x_p0    = widen(in_re, in_im);
        sum_p0  = cadd(d_p0, x_p0);
        diff_p0 = csub(d_p0, x_p0);
        wr_p0   = phase ? diff_p0 : x_p0;
    end

    sdf_delay_line #(
        .DEPTH (DEPTH),
        .DW    (2 * XW)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .en      (in_valid),
        .wr_data (wr_p0),
        .rd_data (d_p0)
    );

    // Frame position and priming. The first phase-0 half after reset has no
    // previous frame to drain, so it stays silent.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= '0;
            primed <= 1'b0;
        end else if (in_valid) begin
            cnt <= cnt + 1'b1;
            if (phase) begin
                primed <= 1'b1;
            end
        end
    end

    // Output stage: register one result per accepted sample. The data holds
    // across idle cycles, and only the valid flag drops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            res_p1 <= '0;
            bf_p1  <= 1'b0;
        end else begin
            vld_p1 <= in_valid & (phase | primed);
            if (in_valid) begin
                res_p1 <= phase ? sum_p0 : d_p0;
                bf_p1  <= phase;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_re    = res_p1.re;
    assign out_im    = res_p1.im;
    assign out_bf    = bf_p1;

endmodule

// File: tb/tb_sdf_bf_stage.sv
// Bench for sdf_bf_stage: four stage depths driven by one shared stream and
// checked against a frame-level reference model, plus hand-computed literals.
module tb_sdf_bf_stage;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                in_valid;
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;

    logic                ov  [4];
    logic                ob  [4];
    logic signed [W:0]   ore [4];
    logic signed [W:0]   oim [4];

    int checks   = 0;
    int failures = 0;
    bit run_chk  = 1'b0;

    // Captured valid outputs of the DEPTH=8 instance and of its model.
    int cap_re [$];
    int cap_im [$];
    int cap_bf [$];
    int mcap_re [$];
    int mcap_bf [$];

    // Literal expectations that are queued by the stimulus and evaluated by the compare process.
    string lq_name [$];
    int    lq_act  [$];
    int    lq_exp  [$];
    int    lq_done = 0;

    for (genvar g = 0; g < 4; g++) begin : gen_d
        localparam int D = 8 >> g;

        sdf_bf_stage #(.WIDTH(W), .DEPTH(D)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_re     (in_re),
            .in_im     (in_im),
            .out_valid (ov[g]),
            .out_re    (ore[g]),
            .out_im    (oim[g]),
            .out_bf    (ob[g])
        );

        // Reference: the current frame and the previous frame are kept as plain arrays.
        // The first half of a frame drains prev[p]-prev[p+D], and the second half emits cur[p-D]+cur[p].
        int fr_re [2*D];
        int fr_im [2*D];
        int pv_re [2*D];
        int pv_im [2*D];
        int pos     = 0;
        int frames  = 0;
        bit e_valid = 1'b0;
        bit e_bf    = 1'b0;
        int e_re    = 0;
        int e_im    = 0;

        always @(posedge clk) begin
            if (!rst) begin
                pos = 0; frames = 0;
                e_valid = 1'b0; e_bf = 1'b0; e_re = 0; e_im = 0;
                for (int i = 0; i < 2*D; i++) begin
                    pv_re[i] = 0; pv_im[i] = 0;
                end
            end else if (in_valid) begin
                fr_re[pos] = int'(in_re);
                fr_im[pos] = int'(in_im);
                if (pos < D) begin
                    e_re = pv_re[pos] - pv_re[pos+D];
                    e_im = pv_im[pos] - pv_im[pos+D];
                    e_bf = 1'b0;
                    e_valid = (frames > 0);
                end else begin
                    e_re = fr_re[pos-D] + fr_re[pos];
                    e_im = fr_im[pos-D] + fr_im[pos];
                    e_bf = 1'b1;
                    e_valid = 1'b1;
                end
                pos++;
                if (pos == 2*D) begin
                    for (int i = 0; i < 2*D; i++) begin
                        pv_re[i] = fr_re[i]; pv_im[i] = fr_im[i];
                    end
                    pos = 0;
                    frames++;
                end
            end else begin
                e_valid = 1'b0;
            end
        end
    end

    task automatic cmp_dut(input int d, input logic v, input logic b,
                           input logic signed [W:0] re, input logic signed [W:0] im,
                           input bit ev, input bit eb, input int er, input int ei);
        logic signed [W:0] xr;
        logic signed [W:0] xi;
        xr = er[W:0];
        xi = ei[W:0];
        checks++;
        if (v !== ev || b !== eb || re !== xr || im !== xi) begin
            failures++;
            $display("FAIL depth%0d_cycle t=%0t actual v=%b bf=%b re=%0d im=%0d required v=%b bf=%b re=%0d im=%0d",
                     d, $time, v, b, re, im, ev, eb, xr, xi);
        end
    endtask

    // Single compare process: it checks every instance against its model on every cycle,
    // captures the outputs, and settles any queued literal expectations.
    always @(negedge clk) begin
        if (run_chk) begin
            cmp_dut(8, ov[0], ob[0], ore[0], oim[0], gen_d[0].e_valid, gen_d[0].e_bf, gen_d[0].e_re, gen_d[0].e_im);
            cmp_dut(4, ov[1], ob[1], ore[1], oim[1], gen_d[1].e_valid, gen_d[1].e_bf, gen_d[1].e_re, gen_d[1].e_im);
            cmp_dut(2, ov[2], ob[2], ore[2], oim[2], gen_d[2].e_valid, gen_d[2].e_bf, gen_d[2].e_re, gen_d[2].e_im);
            cmp_dut(1, ov[3], ob[3], ore[3], oim[3], gen_d[3].e_valid, gen_d[3].e_bf, gen_d[3].e_re, gen_d[3].e_im);
            if (ov[0] === 1'b1) begin
                cap_re.push_back(int'(ore[0]));
                cap_im.push_back(int'(oim[0]));
                cap_bf.push_back(int'(ob[0]));
            end
            if (gen_d[0].e_valid) begin
                mcap_re.push_back(gen_d[0].e_re);
                mcap_bf.push_back(int'(gen_d[0].e_bf));
            end
        end
        while (lq_done < lq_name.size()) begin
            checks++;
            if (lq_act[lq_done] != lq_exp[lq_done]) begin
                failures++;
                $display("FAIL %s actual=%0d required=%0d", lq_name[lq_done], lq_act[lq_done], lq_exp[lq_done]);
            end
            lq_done++;
        end
    end

    task automatic lit(input string n, input int a, input int e);
        lq_name.push_back(n);
        lq_act.push_back(a);
        lq_exp.push_back(e);
    endtask

    task automatic drive(input bit v, input int re, input int im);
        @(negedge clk);
        in_valid = v;
        in_re    = re[W-1:0];
        in_im    = im[W-1:0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic settle();
        drive(0, 0, 0);
        drive(0, 0, 0);
    endtask

    // Basic frame 1..16 followed by 8 zeros. It optionally has an idle cycle with junk data after every sample.
    task automatic run_basic(input bit bubbles);
        for (int i = 1; i <= 24; i++) begin
            drive(1, (i <= 16) ? i : 0, 0);
            if (bubbles) drive(0, 999, -7);
        end
        settle();
    endtask

    task automatic check_basic(input string tag, input int base, input int mbase);
        int er;
        int eb;
        lit({tag, "_count"}, cap_re.size() - base, 16);
        lit({tag, "_model_count"}, mcap_re.size() - mbase, 16);
        for (int i = 0; i < 16; i++) begin
            er = (i < 8) ? 10 + 2*i : -8;
            eb = (i < 8) ? 1 : 0;
            if (base + i < cap_re.size()) begin
                lit($sformatf("%s_re%0d", tag, i), cap_re[base+i], er);
                lit($sformatf("%s_im%0d", tag, i), cap_im[base+i], 0);
                lit($sformatf("%s_bf%0d", tag, i), cap_bf[base+i], eb);
            end
            if (mbase + i < mcap_re.size()) begin
                lit($sformatf("%s_model_re%0d", tag, i), mcap_re[mbase+i], er);
                lit($sformatf("%s_model_bf%0d", tag, i), mcap_bf[mbase+i], eb);
            end
        end
    endtask

    function automatic int rnd_sample();
        case ($urandom_range(7))
            0:       return -32768;
            1:       return 32767;
            default: return int'($signed(16'($urandom)));
        endcase
    endfunction

    task automatic run_random(input int pct_idle);
        for (int i = 0; i < 48; i++) begin
            if ($urandom_range(99) < pct_idle) drive(0, rnd_sample(), rnd_sample());
            drive(1, rnd_sample(), rnd_sample());
        end
        for (int i = 0; i < 8; i++) drive(1, 0, 0);
        settle();
    endtask

    initial begin
        int base;
        int mbase;
        rst = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;
        repeat (3) @(negedge clk);
        run_chk = 1'b1;
        for (int g = 0; g < 4; g++) begin
            lit($sformatf("reset_valid%0d", g), int'(ov[g]), 0);
            lit($sformatf("reset_re%0d", g), int'(ore[g]), 0);
            lit($sformatf("reset_bf%0d", g), int'(ob[g]), 0);
        end
        rst = 1'b1;

        // Basic frame.
        base = cap_re.size(); mbase = mcap_re.size();
        run_basic(1'b0);
        check_basic("basic", base, mbase);

        // Mid-frame reset: the stream continues with 1..5 as phase-1 sums, then a one-cycle reset is applied.
        for (int i = 1; i <= 5; i++) drive(1, i, 0);
        @(negedge clk);
        lit("pre_rst_re", int'(ore[0]), 5);
        lit("pre_rst_bf", int'(ob[0]), 1);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            lit($sformatf("midrst_valid%0d", g), int'(ov[g]), 0);
            lit($sformatf("midrst_re%0d", g), int'(ore[g]), 0);
            lit($sformatf("midrst_bf%0d", g), int'(ob[g]), 0);
        end
        rst = 1'b1;
        base = cap_re.size(); mbase = mcap_re.size();
        run_basic(1'b0);
        check_basic("restart", base, mbase);

        // Bubbles on every other cycle.
        do_reset();
        base = cap_re.size(); mbase = mcap_re.size();
        run_basic(1'b1);
        check_basic("bubble", base, mbase);

        // Growth extremes.
        do_reset();
        base = cap_re.size();
        for (int i = 0; i < 8; i++)  drive(1, 32767, 32767);
        for (int i = 0; i < 24; i++) drive(1, -32768, -32768);
        for (int i = 0; i < 8; i++)  drive(1, 0, 0);
        settle();
        lit("growth_count", cap_re.size() - base, 32);
        if (cap_re.size() >= base + 32) begin
            lit("growth_sum_re", cap_re[base], -1);
            lit("growth_sum_im", cap_im[base], -1);
            lit("growth_sum_bf", cap_bf[base], 1);
            lit("growth_diff_re", cap_re[base+8], 65535);
            lit("growth_diff_im", cap_im[base+8], 65535);
            lit("growth_diff_bf", cap_bf[base+8], 0);
            lit("growth_neg_re", cap_re[base+16], -65536);
            lit("growth_neg_im", cap_im[base+16], -65536);
            lit("growth_drain_re", cap_re[base+24], 0);
        end

        // Random continuous streams, then random streams with bubbles.
        do_reset();
        run_random(0);
        do_reset();
        run_random(30);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdf_bf_stage.md
# sdf_bf_stage

Radix-2 single-path delay-feedback (SDF) butterfly stage for the 16-point radix-2² FFT pipeline. It accepts one complex sample per valid cycle, pairs each sample with the sample DEPTH positions earlier through an internal feedback delay line, and emits sums and differences in SDF order. It sits directly upstream of the registered 2:1 feedback/output mux and the twiddle stage. It owns the stage's control counter and exports the butterfly phase so the downstream mux select is derived from it.

## Interface
- WIDTH, 16: bit width of each input real/imag component (signed two's complement).
- DEPTH, 8: delay-line length in complex samples. Power of two, ≥1; 8/4/2/1 for the four stages.
- clk  in  1  rising-edge clock.
- rst  in  1  reset. One clock; reset is synchronous and active-low.
- in_valid  in  1  input sample present this cycle. There is no backpressure; the stage always accepts.
- in_re, in_im  in  WIDTH each  signed input sample.
- out_valid  out  1  output sample valid; reset 0.
- out_re, out_im  out  WIDTH+1 each  signed output sample; reset 0.
- out_bf  out  1  1 = output is a butterfly sum, 0 = output is a drained difference; reset 0. Feeds the downstream mux Selection.

## Operation
- Counter `cnt`, width log2(DEPTH)+1, counts accepted samples modulo 2·DEPTH. It advances only when in_valid=1. `phase` = cnt[MSB]: 0 for cnt<DEPTH, 1 otherwise.
- Delay line: circular buffer of DEPTH entries, each 2×(WIDTH+1) bits, with one pointer. The pointer advances on in_valid only. On each accepted sample the old entry is read and the new entry is written in the same cycle (read-before-write). d = entry read.
- x = in sign-extended to WIDTH+1.
- Phase 0 (accepted sample): write x; output d (the difference stored by the previous frame); out_bf=0.
- Phase 1 (accepted sample): output d+x; write d−x; out_bf=1. Both are computed in WIDTH+1 bits. No saturation and no rounding is needed: |x|≤2^(WIDTH−1), so results always fit.
- Priming flag `primed`: reset 0; set on the first accepted phase-1 sample; stays set until reset.
- out_valid is registered in_valid & (phase | primed). Phase-0 outputs of the first frame after reset are suppressed.
- Idle cycles (in_valid=0): cnt, pointer, delay contents and primed are held. out_valid goes 0, and out_re/out_im/out_bf hold their last values.
- Reset (rst=0 at a clock edge), including mid-frame:
  - cnt, pointer, primed, out_* are set to 0.
  - All delay entries are set to 0.
  - Data from a partial frame is discarded.
  - The first accepted sample after reset is frame position 0.
- A 2·DEPTH wrap happens with no bubble: position 2·DEPTH−1 is followed immediately by position 0 of the next frame.

## Timing
- Latency is 1 clock: a sample accepted at edge k produces out_* visible after edge k; out_valid is high in cycle k+1.
- Throughput is 1 sample/clock, sustained.
- Output order for frame f:
  - DEPTH difference outputs from frame f−1.
  - Then DEPTH sums from frame f.
- Differences from the final frame appear only while the next frame's first DEPTH samples are input. A stream must be followed by DEPTH more valid samples (zeros allowed) to drain.
- All outputs are flops. There is no combinational path from input to output.

## Structure
- Shared package fft_pkg holds:
  - Default WIDTH and the stage DEPTH constants (8, 4, 2, 1).
  - A complex sample typedef parameterised on width.
  - The counter-width function log2(DEPTH)+1.
- Sub-module sdf_delay_line (DEPTH, DW) contains the circular buffer, pointer, enable and synchronous clear.
- The top level holds the counter, primed flag, add/sub and output registers.

## Test plan
- Basic frame, DEPTH=8, in_im=0, in_re = 1..16 back-to-back, then 8 zeros:
  - First 8 inputs produce no out_valid.
  - Inputs 9–16 give out_re=10,12,…,24 with out_bf=1, 1 cycle after each input.
  - The zeros give out_re=−8 ×8 with out_bf=0.
- Growth extremes: frame pair x=32767 (re/im) against −32768 gives sum −1 and difference 65535. Both x=−32768 gives sum −65536. Both must be exact in 17 bits.
- Bubbles: same stimulus as the basic frame with in_valid low on every other cycle. Identical output sequence, out_valid only the cycle after each accepted sample, and all state held during gaps.
- Mid-frame reset: rst=0 for 1 cycle after input 5, then restart 1..16.
  - All outputs are 0 during reset.
  - Results match the basic frame exactly, with no stale data from the aborted frame.
- Continuous streaming, DEPTH=1/2/4/8: random 3-frame streams checked against a reference model. out_bf toggles every DEPTH valid outputs after priming, and there is no bubble at wrap.
